// File: rtl/dl_rr_arb_mux.sv
// dl_rr_arb_mux: N-to-1 round-robin arbitrating mux with a one-entry
// registered output stage. Each input and the output use valid/ready
// handshakes. The arbiter searches for a requester starting at ptr and
// wraps around. After every accepted word, ptr moves to the slot just
// past the winner.

module dl_rr_arb_mux #(
    parameter  int NUM_INPUTS = 32,
    parameter  int NUM_BITS   = 32,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*NUM_BITS-1:0]   in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [NUM_BITS-1:0]              out_data,
    output logic [SEL_WIDTH-1:0]             out_sel,
    output logic                             out_valid,
    input  logic                             out_ready
);

    // Output register and round-robin pointer.
    logic [NUM_BITS-1:0]   out_data_q,  out_data_d;
    logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  ptr_q,       ptr_d;

    // Arbitration signals.
    logic [NUM_INPUTS-1:0] req_hi;      // requesters at or above ptr
    logic [NUM_INPUTS-1:0] grant_hi;
    logic [NUM_INPUTS-1:0] grant_lo;
    logic [NUM_INPUTS-1:0] grant;
    logic [SEL_WIDTH-1:0]  idx_term  [NUM_INPUTS];
    logic [NUM_BITS-1:0]   data_term [NUM_INPUTS];
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [NUM_BITS-1:0]   grant_data;
    logic                  load_en;
    logic                  transfer;

    // Per-channel mask and one-hot decode. The winner's index and data are
    // formed by OR-reducing terms, so no wide variable part-select is built.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
        assign req_hi[gi]    = in_valid[gi] && (ptr_q <= SEL_WIDTH'(gi));
        assign idx_term[gi]  = grant[gi] ? SEL_WIDTH'(gi) : '0;
        assign data_term[gi] = grant[gi] ? in_data[gi*NUM_BITS +: NUM_BITS] : '0;
    end

    // v & -v isolates the lowest set bit. If no request lies at or above
    // ptr, the search wraps to the lowest requesting channel overall.
    assign grant_hi = req_hi   & (~req_hi   + NUM_INPUTS'(1));
    assign grant_lo = in_valid & (~in_valid + NUM_INPUTS'(1));
    assign grant    = (|req_hi) ? grant_hi : grant_lo;

    // Reduce the one-hot winner into its index and its data word.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant_idx  = grant_idx  | idx_term[i];
            grant_data = grant_data | data_term[i];
        end
    end

    assign load_en  = !out_valid_q || out_ready;
    assign transfer = load_en && (|in_valid);

    // rst_n gates in_ready so that no producer sees an accept while in reset.
    assign in_ready = grant & {NUM_INPUTS{load_en && rst_n}};

    // Next state: load the winner, drain on output accept, otherwise hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            // Explicit wrap, because NUM_INPUTS need not be a power of two.
            ptr_d       = (grant_idx == SEL_WIDTH'(NUM_INPUTS - 1)) ?
                          '0 : grant_idx + SEL_WIDTH'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; reset asserts asynchronously and discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dl_rr_arb_mux.sv
// Testbench for dl_rr_arb_mux. The 32x32 instance (A) covers most
// scenarios. The 5x8 instance (B) covers the non-power-of-two wrap.
// A reference model predicts in_ready, pushes each expected word into a
// scoreboard queue, and pops the queue when the output register loads.

module tb_dl_rr_arb_mux;

    typedef struct {
        int          sel;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: 32 channels x 32 bits.
    logic [32*32-1:0] in_data_a;
    logic [31:0]      in_valid_a;
    logic [31:0]      in_ready_a;
    logic [31:0]      out_data_a;
    logic [4:0]       out_sel_a;
    logic             out_valid_a;
    logic             out_ready_a;

    // Instance B: 5 channels x 8 bits.
    logic [5*8-1:0]   in_data_b;
    logic [4:0]       in_valid_b;
    logic [4:0]       in_ready_b;
    logic [7:0]       out_data_b;
    logic [2:0]       out_sel_b;
    logic             out_valid_b;
    logic             out_ready_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit auto_drop = 1'b0;

    // Reference-model state for each instance.
    int          ptr_a, sel_a, ptr_b, sel_b;
    bit          val_a, val_b;
    logic [31:0] dat_a, dat_b;
    word_t       q_a[$];
    word_t       q_b[$];

    dl_rr_arb_mux #(.NUM_INPUTS(32), .NUM_BITS(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_sel(out_sel_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    dl_rr_arb_mux #(.NUM_INPUTS(5), .NUM_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_sel(out_sel_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    always #5 clk = ~clk;

    // Search order is ptr, ptr+1, ..., wrapping modulo n.
    function automatic int mdl_grant(input logic [31:0] v, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        ptr_a = 0; sel_a = 0; val_a = 1'b0; dat_a = '0; q_a.delete();
        ptr_b = 0; sel_b = 0; val_b = 1'b0; dat_b = '0; q_b.delete();
    endtask

    task automatic clear_inputs();
        in_valid_a = '0; in_valid_b = '0;
        out_ready_a = 1'b0; out_ready_b = 1'b0;
    endtask

    // One clock cycle. in_ready is checked at the negedge and the expected
    // word is pushed there. The register state is checked 1 time unit
    // after the posedge.
    task automatic run_cycle();
        int          ga, gb;
        logic [31:0] er_a;
        logic [4:0]  er_b;
        bit          ld_a, ld_b;
        word_t       w;
        @(negedge clk);
        ga = mdl_grant(in_valid_a, ptr_a, 32);
        gb = mdl_grant({27'd0, in_valid_b}, ptr_b, 5);
        er_a = '0; er_b = '0; ld_a = 1'b0; ld_b = 1'b0;
        if (rst_n && (!val_a || out_ready_a) && ga >= 0) begin
            er_a[ga] = 1'b1; ld_a = 1'b1;
            q_a.push_back('{ga, in_data_a[ga*32 +: 32]});
        end
        if (rst_n && (!val_b || out_ready_b) && gb >= 0) begin
            er_b[gb] = 1'b1; ld_b = 1'b1;
            q_b.push_back('{gb, {24'd0, in_data_b[gb*8 +: 8]}});
        end
        n_cmp++;
        if (in_ready_a !== er_a) begin
            n_fail++; $display("FAIL in_ready_a: got %h want %h", in_ready_a, er_a);
        end
        n_cmp++;
        if (in_ready_b !== er_b) begin
            n_fail++; $display("FAIL in_ready_b: got %h want %h", in_ready_b, er_b);
        end
        @(posedge clk); #1;
        if (!rst_n) begin
            mdl_reset();
        end else begin
            if (ld_a) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL scoreboard_a: got empty want entry");
                end else begin
                    w = q_a.pop_front();
                    sel_a = w.sel; dat_a = w.data; val_a = 1'b1;
                    ptr_a = (w.sel == 31) ? 0 : w.sel + 1;
                end
                if (auto_drop) in_valid_a[ga] = 1'b0;
            end else if (val_a && out_ready_a) begin
                val_a = 1'b0;
            end
            if (ld_b) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL scoreboard_b: got empty want entry");
                end else begin
                    w = q_b.pop_front();
                    sel_b = w.sel; dat_b = w.data; val_b = 1'b1;
                    ptr_b = (w.sel == 4) ? 0 : w.sel + 1;
                end
                if (auto_drop) in_valid_b[gb] = 1'b0;
            end else if (val_b && out_ready_b) begin
                val_b = 1'b0;
            end
        end
        n_cmp++;
        if (out_valid_a !== val_a) begin
            n_fail++; $display("FAIL out_valid_a: got %b want %b", out_valid_a, val_a);
        end
        n_cmp++;
        if (out_valid_b !== val_b) begin
            n_fail++; $display("FAIL out_valid_b: got %b want %b", out_valid_b, val_b);
        end
        if (val_a) begin
            n_cmp++;
            if (int'(out_sel_a) !== sel_a || out_data_a !== dat_a) begin
                n_fail++;
                $display("FAIL word_a: got sel=%0d data=%h want sel=%0d data=%h",
                         out_sel_a, out_data_a, sel_a, dat_a);
            end
        end
        if (val_b) begin
            n_cmp++;
            if (int'(out_sel_b) !== sel_b || {24'd0, out_data_b} !== dat_b) begin
                n_fail++;
                $display("FAIL word_b: got sel=%0d data=%h want sel=%0d data=%h",
                         out_sel_b, out_data_b, sel_b, dat_b);
            end
        end
        n_cmp++;
        if (int'(dut_a.ptr_q) !== ptr_a) begin
            n_fail++; $display("FAIL ptr_a: got %0d want %0d", dut_a.ptr_q, ptr_a);
        end
        n_cmp++;
        if (int'(dut_b.ptr_q) !== ptr_b || dut_b.ptr_q > 3'd4) begin
            n_fail++; $display("FAIL ptr_b: got %0d want %0d", dut_b.ptr_q, ptr_b);
        end
        $display("cycle t=%0t A: vld=%b sel=%0d data=%h | B: vld=%b sel=%0d data=%h",
                 $time, out_valid_a, out_sel_a, out_data_a, out_valid_b, out_sel_b, out_data_b);
    endtask

    // Synchronous-style reset pulse used between scenarios.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        mdl_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_a(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++; $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        in_valid_a = '1;
        for (int i = 0; i < 32; i++) in_data_a[i*32 +: 32] = 32'hA000_0000 + i;
        mdl_reset();
        #12;
        check_a("reset_in_ready", in_ready_a, 32'd0);
        check_a("reset_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_a("reset_out_data", out_data_a, 32'd0);
        check_a("reset_out_sel", {27'd0, out_sel_a}, 32'd0);
        in_valid_a = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Load a word and keep it held, then assert reset asynchronously mid-cycle.
        in_valid_a = 32'h4; out_ready_a = 1'b0;
        run_cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check_a("async_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_a("async_out_data", out_data_a, 32'd0);
        check_a("async_out_sel", {27'd0, out_sel_a}, 32'd0);
        check_a("async_in_ready", in_ready_a, 32'd0);
        check_a("async_ptr", {27'd0, dut_a.ptr_q}, 32'd0);
        mdl_reset();
        in_valid_a = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        auto_drop = 1'b1;
        in_data_a[7*32 +: 32] = 32'hDEAD_BEEF;
        in_valid_a = 32'h1 << 7;
        out_ready_a = 1'b1;
        run_cycle();
        check_a("single_sel", {27'd0, out_sel_a}, 32'd7);
        check_a("single_data", out_data_a, 32'hDEAD_BEEF);
        check_a("single_ptr", {27'd0, dut_a.ptr_q}, 32'd8);
        run_cycle();
    endtask

    task automatic test_round_robin();
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < 32; i++) in_data_a[i*32 +: 32] = i;
        in_valid_a = '1;
        out_ready_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            run_cycle();
            check_a("rr_valid", {31'd0, out_valid_a}, 32'd1);
            check_a("rr_sel", {27'd0, out_sel_a}, c % 32);
        end
        in_valid_a = '0;
        run_cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        auto_drop = 1'b1;
        in_data_a[3*32 +: 32] = 32'h3333_0003;
        in_data_a[5*32 +: 32] = 32'h5555_0005;
        in_valid_a = (32'h1 << 3) | (32'h1 << 5);
        out_ready_a = 1'b1;
        run_cycle();
        out_ready_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            check_a("bp_hold_sel", {27'd0, out_sel_a}, 32'd3);
            check_a("bp_in_ready", in_ready_a, 32'd0);
        end
        out_ready_a = 1'b1;
        run_cycle();
        check_a("bp_release_sel", {27'd0, out_sel_a}, 32'd5);
        check_a("bp_release_data", out_data_a, 32'h5555_0005);
        run_cycle();
        check_a("bp_drained", {31'd0, out_valid_a}, 32'd0);
        check_a("bp_sel_holds", {27'd0, out_sel_a}, 32'd5);
    endtask

    task automatic test_wrap();
        do_reset();
        auto_drop = 1'b1;
        for (int i = 0; i < 5; i++) in_data_b[i*8 +: 8] = 8'hB0 + 8'(i);
        out_ready_b = 1'b1;
        in_valid_b = 5'b01000;
        run_cycle();
        check_a("wrap_ptr4", {29'd0, dut_b.ptr_q}, 32'd4);
        in_valid_b = 5'b10001;
        run_cycle();
        check_a("wrap_sel4", {29'd0, out_sel_b}, 32'd4);
        check_a("wrap_ptr0", {29'd0, dut_b.ptr_q}, 32'd0);
        run_cycle();
        check_a("wrap_sel0", {29'd0, out_sel_b}, 32'd0);
        check_a("wrap_data0", {24'd0, out_data_b}, 32'h0000_00B0);
        run_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < 32; i++) in_data_a[i*32 +: 32] = 32'h100 + i;
        in_valid_a = '1;
        out_ready_a = 1'b1;
        repeat (3) run_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_a("mid_async_valid", {31'd0, out_valid_a}, 32'd0);
        mdl_reset();
        repeat (2) run_cycle();
        rst_n = 1'b1;
        run_cycle();
        check_a("mid_first_sel", {27'd0, out_sel_a}, 32'd0);
        check_a("mid_first_data", out_data_a, 32'h100);
        run_cycle();
        check_a("mid_second_sel", {27'd0, out_sel_a}, 32'd1);
    endtask

    initial begin
        in_data_a = '0;
        in_data_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_rr_arb_mux.md
# dl_rr_arb_mux

Parametrised, registered N-to-1 round-robin arbitrating mux with valid/ready handshakes on every input and on the output. It is the sequential successor to the fixed 32-input combinational mux. Software-driven selection is replaced by fair hardware arbitration among requesting inputs, and the result goes through a one-entry output register. It sits wherever several producers share one downstream consumer, for example register-file write-back or bus request merging.

## Interface
- NUM_INPUTS, default 32: number of input channels; any value ≥ 2, power of two not required.
- NUM_BITS, default 32: data width per channel.
- SEL_WIDTH, derived localparam: $clog2(NUM_INPUTS); not overridable.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts asynchronously.
- in_data  input  NUM_INPUTS*NUM_BITS  flattened inputs; channel i occupies bits [i*NUM_BITS +: NUM_BITS].
- in_valid  input  NUM_INPUTS  per-channel request.
- in_ready  output  NUM_INPUTS  per-channel accept; at most one bit high per cycle.
- out_data  output  NUM_BITS  registered selected data.
- out_sel  output  SEL_WIDTH  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.

## Operation
- State:
  - output register (out_data, out_sel, out_valid);
  - round-robin pointer ptr, SEL_WIDTH bits, range 0..NUM_INPUTS-1.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
- Load enable: load_en = !out_valid || out_ready.
- Grant:
  - the first i with in_valid[i]=1, searching i = ptr, ptr+1, …, NUM_INPUTS-1, 0, …, ptr-1;
  - at most one grant per cycle;
  - no grant when in_valid is all zeros.
- in_ready[i] = load_en && grant[i]. Combinational from in_valid, out_valid and out_ready.
- Transfer on channel i: in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data;
  - out_sel <= i;
  - out_valid <= 1;
  - ptr <= (i == NUM_INPUTS-1) ? 0 : i+1. Explicit wrap; no modulo-2^SEL_WIDTH.
- Output drain: out_valid && out_ready with no new transfer gives out_valid <= 0. out_data and out_sel hold their last values.
- Drain and load in the same cycle: the register is overwritten with the new word and out_valid stays 1. Full throughput, no bubble.
- Backpressure: while out_valid && !out_ready:
  - out_data, out_sel and out_valid hold;
  - all in_ready stay 0;
  - ptr holds.
- No transfer: ptr holds.
- Producer rules:
  - a producer must not make in_valid depend on in_ready;
  - once asserted, in_valid and the data are held until accepted. The block does not check this.
- Fairness: each continuously requesting channel is granted within NUM_INPUTS transfers.

## Timing
- Latency: 1 cycle, from the accepting edge to out_valid/out_data valid.
- Throughput: 1 word per cycle while out_ready=1 and any in_valid=1.
- in_ready is valid in the same cycle as in_valid. out_valid, out_data and out_sel are registered outputs only.
- Reset mid-operation:
  - rst_n low immediately clears out_valid and ptr, whatever the clock is doing;
  - a word held in the register is discarded;
  - in_ready drops to 0 while in reset.
- First transfer is possible on the first rising edge after rst_n deasserts.

## Test plan
- Reset, NUM_INPUTS=32, NUM_BITS=32. Assert rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 before the next edge; in_ready=0.
- Single requester. in_valid=1<<7, data 0xDEADBEEF, out_ready=1 -> in_ready[7]=1 in the same cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=7; ptr=8.
- All 32 channels valid, channel i data = i, out_ready=1 for 40 cycles -> out_sel sequence 0,1,…,31,0,1,…; one word per cycle, no bubbles.
- Backpressure. Channels 3 and 5 valid, out_ready=0 after the first load -> out_sel=3 held stable for 5 cycles and in_ready=0. Release out_ready -> next word is out_sel=5 in the following cycle.
- Non-power-of-two wrap, NUM_INPUTS=5. Channels 4 and 0 valid, ptr=4 -> grant 4, ptr wraps to 0, then grant 0. ptr never takes values 5..7.
- Reset mid-stream. All channels valid, rst_n pulsed low for 2 cycles during transfers -> after release the first grant is channel 0 and no pre-reset word appears on out_data.
